// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle arithmetic/logic/shift ops, radix-2 Booth MUL
// and restoring DIV; results held in ResultHi/ResultLo until the next completion.
module seq_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] RA,
  input  logic [WIDTH-1:0] RB,
  input  logic [4:0]       Op,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] ResultHi,
  output logic [WIDTH-1:0] ResultLo
);

  typedef enum logic [4:0] {
    OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b00101, OP_OR   = 5'b00110,
    OP_ROR  = 5'b00111, OP_ROL  = 5'b01000, OP_SHR  = 5'b01001, OP_SHRA = 5'b01010,
    OP_SHL  = 5'b01011, OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI  = 5'b01110,
    OP_DIV  = 5'b01111, OP_MUL  = 5'b10000, OP_NEG  = 5'b10001, OP_NOT  = 5'b10010
  } op_e;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DFIX} state_e;

  state_e             state;
  logic [SHAMT_W-1:0] cnt;
  logic               dz_pend;
  logic [WIDTH:0]     a;
  logic [WIDTH-1:0]   q, mcand;
  logic               q1;
  logic [WIDTH-1:0]   rem, quo, dvsr;
  logic               sign_r, sign_q;

  logic [SHAMT_W-1:0] shamt;
  logic [SHAMT_W:0]   inv;
  logic [WIDTH-1:0]   alu, mag_a, mag_b;
  logic [WIDTH:0]     m_ext, a_sum, a_n;
  logic [WIDTH-1:0]   q_n;
  logic               q1_n;
  logic [WIDTH:0]     shifted, trial;
  logic [WIDTH-1:0]   rem_n, quo_n;

  always_comb begin
    shamt = RB[SHAMT_W-1:0];
    inv   = (SHAMT_W+1)'(WIDTH) - {1'b0, shamt};
    case (Op)
      OP_ADD, OP_ADDI: alu = RA + RB;
      OP_SUB:          alu = RA - RB;
      OP_AND, OP_ANDI: alu = RA & RB;
      OP_OR, OP_ORI:   alu = RA | RB;
      // a shift by inv == WIDTH yields zero, so amount 0 rotates correctly
      OP_ROR:          alu = (RA >> shamt) | (RA << inv);
      OP_ROL:          alu = (RA << shamt) | (RA >> inv);
      OP_SHR:          alu = RA >> shamt;
      OP_SHRA:         alu = $signed(RA) >>> shamt;
      OP_SHL:          alu = RA << shamt;
      OP_NEG:          alu = '0 - RB;
      OP_NOT:          alu = ~RB;
      default:         alu = '0;
    endcase

    mag_a = RA[WIDTH-1] ? '0 - RA : RA;
    mag_b = RB[WIDTH-1] ? '0 - RB : RB;

    // Booth step: one extra accumulator bit absorbs the -2^(W-1) multiplicand
    m_ext = {mcand[WIDTH-1], mcand};
    case ({q[0], q1})
      2'b01:   a_sum = a + m_ext;
      2'b10:   a_sum = a - m_ext;
      default: a_sum = a;
    endcase
    a_n  = {a_sum[WIDTH], a_sum[WIDTH:1]};
    q_n  = {a_sum[0], q[WIDTH-1:1]};
    q1_n = q[0];

    shifted = {rem, quo[WIDTH-1]};
    trial   = shifted - {1'b0, dvsr};
    if (trial[WIDTH]) begin
      rem_n = shifted[WIDTH-1:0];
      quo_n = {quo[WIDTH-2:0], 1'b0};
    end else begin
      rem_n = trial[WIDTH-1:0];
      quo_n = {quo[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state       <= S_IDLE;
      cnt         <= '0;
      dz_pend     <= 1'b0;
      a           <= '0;
      q           <= '0;
      q1          <= 1'b0;
      mcand       <= '0;
      rem         <= '0;
      quo         <= '0;
      dvsr        <= '0;
      sign_r      <= 1'b0;
      sign_q      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      ResultHi    <= '0;
      ResultLo    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (dz_pend) begin
            // divide-by-zero finishes one edge later, dividend parked in quo
            dz_pend     <= 1'b0;
            ResultLo    <= '1;
            ResultHi    <= quo;
            div_by_zero <= 1'b1;
            done        <= 1'b1;
            busy        <= 1'b0;
          end else if (start) begin
            div_by_zero <= 1'b0;
            cnt         <= '0;
            if (Op == OP_MUL) begin
              a     <= '0;
              q     <= RB;
              q1    <= 1'b0;
              mcand <= RA;
              busy  <= 1'b1;
              state <= S_MUL;
            end else if (Op == OP_DIV) begin
              busy <= 1'b1;
              if (RB == '0) begin
                dz_pend <= 1'b1;
                quo     <= RA;
              end else begin
                rem    <= '0;
                quo    <= mag_a;
                dvsr   <= mag_b;
                sign_r <= RA[WIDTH-1];
                sign_q <= RA[WIDTH-1] ^ RB[WIDTH-1];
                state  <= S_DIV;
              end
            end else begin
              ResultLo <= alu;
              ResultHi <= '0;
              done     <= 1'b1;
            end
          end
        end
        S_MUL: begin
          a   <= a_n;
          q   <= q_n;
          q1  <= q1_n;
          cnt <= cnt + 1'b1;
          if (cnt == '1) begin
            ResultHi <= a_n[WIDTH-1:0];
            ResultLo <= q_n;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end
        end
        S_DIV: begin
          rem <= rem_n;
          quo <= quo_n;
          cnt <= cnt + 1'b1;
          if (cnt == '1) state <= S_DFIX;
        end
        S_DFIX: begin
          ResultLo <= sign_q ? '0 - quo : quo;
          ResultHi <= sign_r ? '0 - rem : rem;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised multi-cycle ALU for the datapath, replacing the purely combinational ALU stage. Single-cycle ops (add/sub/logic/shift/rotate/neg/not) complete in one clock; MUL (radix-2 Booth, signed) and DIV (restoring, signed) iterate over WIDTH cycles. Operands are sampled on a start handshake. The 2×WIDTH result is held in registered ResultHi/ResultLo until the next completion, for the Z register to capture on done.

## Interface
- WIDTH, 32, operand/result width; power of two, ≥ 4
- SHAMT_W, $clog2(WIDTH), derived shift-amount width; not to be overridden
- clock  in  1  system clock, rising edge
- clear  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only while busy=0
- RA  in  WIDTH  operand A / dividend / multiplicand
- RB  in  WIDTH  operand B / divisor / multiplier / immediate / shift amount
- Op  in  5  operation code
- busy  out  1  operation in progress; start ignored
- done  out  1  one-cycle pulse: ResultHi/ResultLo just updated
- div_by_zero  out  1  set with done when DIV had RB=0; cleared on next accepted start
- ResultHi  out  WIDTH  high product half / remainder / 0
- ResultLo  out  WIDTH  low product half / quotient / result

## Operation
- Opcodes: ADD 00011, SUB 00100, AND 00101, OR 00110, ROR 00111, ROL 01000, SHR 01001, SHRA 01010, SHL 01011, ADDI 01100, ANDI 01101, ORI 01110, DIV 01111, MUL 10000, NEG 10001, NOT 10010.
- ADDI/ANDI/ORI behave as ADD/AND/OR. RB already carries the sign-extended immediate.
- Single-cycle ops write ResultLo; ResultHi=0. Add/sub wrap modulo 2^WIDTH; no carry output.
  - NEG = 0−RB.
  - NOT = ~RB.
- Shifts and rotates use RB[SHAMT_W-1:0]; upper RB bits are ignored.
  - SHR and SHL fill with zeros.
  - SHRA fills with RA[WIDTH-1].
- Undefined Op: ResultHi=ResultLo=0, completes as a single-cycle op.
- MUL: signed RA×RB, 2×WIDTH product. ResultHi = product[2W-1:W], ResultLo = product[W-1:0]. One Booth step per cycle, WIDTH steps.
- DIV: signed, quotient truncated toward zero. Remainder takes the dividend's sign.
  - Iterates on magnitudes for WIDTH cycles, then one sign-fix cycle.
  - ResultLo = quotient, ResultHi = remainder.
  - −2^(W−1) / −1: quotient −2^(W−1) (wraps), remainder 0.
- DIV with RB=0: no iteration. ResultLo = all ones, ResultHi = RA, div_by_zero=1.
- FSM states:
  - IDLE: on start, go to MUL or DIV, or stay in IDLE for single-cycle ops and DIV-by-zero.
  - MUL: exit to IDLE after step counter reaches WIDTH.
  - DIV: go to DFIX after WIDTH steps.
  - DFIX: go to IDLE.
- ResultHi/ResultLo change only on a completion edge. Between completions they hold.

## Timing
- Edge 0 is the rising edge sampling start=1 with busy=0. Operands and Op are captured there; they may change afterwards.
- Single-cycle op: results written and done=1 at edge 0. Latency 1, busy stays 0, back-to-back issue allowed every cycle.
- DIV by zero: results written and done=1 at edge 1. busy=1 for one cycle.
- MUL: busy=1 from edge 0. Results written, done=1, busy=0 at edge WIDTH.
- DIV: busy=1 from edge 0. Results written, done=1, busy=0 at edge WIDTH+1.
- done is high for exactly one cycle per accepted start. start in the same cycle as done (busy=0) is accepted.
- start while busy=1 is ignored: no queueing, no effect on the running op.
- clear, at any time and asynchronously:
  - FSM → IDLE, counters 0.
  - busy=0, done=0, div_by_zero=0, ResultHi=ResultLo=0.
  - An in-flight op is discarded; no done is produced for it.
- Reset values: all outputs 0.

## Test plan
- ADD, RA=7, RB=0xFFFFFFFD (−3), WIDTH=32 → at edge 0: ResultLo=0x00000004, ResultHi=0, done=1 one cycle, busy never 1.
- MUL, RA=0xFFFFFFFA (−6), RB=7 → busy 32 cycles; at edge 32: ResultHi=0xFFFFFFFF, ResultLo=0xFFFFFFD6, done pulse. MUL 0x80000000×0x80000000 → ResultHi=0x40000000, ResultLo=0.
- DIV, RA=0xFFFFFFEF (−17), RB=5 → at edge 33: ResultLo=0xFFFFFFFD (−3), ResultHi=0xFFFFFFFE (−2), div_by_zero=0.
- DIV, RA=5, RB=0 → at edge 1: ResultLo=0xFFFFFFFF, ResultHi=5, div_by_zero=1. Next ADD start clears div_by_zero.
- Shift checks, all results in ResultLo:
  - ROR 0x80000001 by RB=0x21 (amount 1) → 0xC0000000.
  - SHRA 0x80000000 by 4 → 0xF8000000.
  - SHR 0x80000000 by 4 → 0x08000000.
  - ROL 0x80000001 by 1 → 0x00000003.
- MUL started; start pulsed with ADD at cycle 5 → ignored, MUL result unaffected. clear asserted mid-cycle at cycle 10 of a second MUL → immediately busy=0, results 0, no done. A following ADD 1+1 → ResultLo=2 at its edge 0.
